// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and sizes for the four-requester round-robin
//               arbiter (rr_arbiter_4) and its grant index decoder.
//               Contents:
//                 N_REQ       - number of requesters
//                 IDX_W       - width of a requester index
//                 arb_state_t - arbiter state (idle / granted)
//                 arb_idx_t   - requester index type
//                 arb_pick_t  - result of a priority search (found + index)
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    typedef logic [IDX_W-1:0] arb_idx_t;

    typedef struct packed {
        logic     found;
        arb_idx_t idx;
    } arb_pick_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_idx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : arb_idx_decoder
// Description : 2-to-4 index decoder with enable. Turns the registered grant
//               index / valid pair into the one-hot grant vector.
// Ports       : idx    in  [IDX_W-1:0] binary requester index
//               en     in  1           decode enable (grant valid)
//               onehot out [N_REQ-1:0] one-hot of idx, all zeros when en=0
// Revision    : 1.0 - initial release
// ============================================================================
module arb_idx_decoder
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    for (genvar g = 0; g < N_REQ; g++) begin : g_onehot
        assign onehot[g] = en && (idx == arb_idx_t'(g));
    end

endmodule : arb_idx_decoder
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_4
// Description : Four-requester round-robin arbiter with request/hold/release
//               ownership. The owner keeps the grant while its request is
//               high; on release the next requester after the previous owner
//               (rotating pointer) takes over on the following edge with no
//               idle cycle in between.
//               Optional macro ARB_TIMEOUT_EN: an owner that has held the
//               grant for MAX_HOLD cycles while another requester waits is
//               forcibly preempted, flagged by a one-cycle timeout_pulse.
// Parameters  : MAX_HOLD      - grant cycles before forced preemption (>= 2),
//                               only meaningful with ARB_TIMEOUT_EN
// Ports       : clk           in  1  clock, rising edge
//               rst_n         in  1  asynchronous active-low reset
//               req           in  4  request vector
//               grant         out 4  one-hot grant, zero when no owner
//               grant_idx     out 2  owner index, holds last owner when idle
//               grant_valid   out 1  high when grant is nonzero
//               timeout_pulse out 1  one-cycle forced-preemption flag
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout_pulse
);

    if (MAX_HOLD < 2) begin : g_max_hold_check
        $error("rr_arbiter_4: MAX_HOLD must be at least 2");
    end

    // Rotating-priority search: candidates are visited starting one past
    // the previous winner, so the previous winner itself is examined last.
    function automatic arb_pick_t f_rr_pick(input logic [N_REQ-1:0] cand,
                                            input arb_idx_t         last);
        arb_pick_t pick;
        arb_idx_t  slot;
        pick = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            slot = last + arb_idx_t'(k);
            if (!pick.found && cand[slot]) begin
                pick.found = 1'b1;
                pick.idx   = slot;
            end
        end
        return pick;
    endfunction

    arb_state_t       r_state;
    arb_idx_t         r_grant_idx;
    arb_idx_t         r_last_idx;

    logic             w_owner_req;
    logic [N_REQ-1:0] w_cand;
    arb_pick_t        w_pick;
    logic             w_force;
    logic             w_rearb;

    // grant is a pure decode of registered state, so it drops the instant
    // reset asserts and can never be anything other than one-hot or zero.
    arb_idx_decoder u_idx_decoder (
        .idx    (r_grant_idx),
        .en     (r_state == ARB_GRANT),
        .onehot (grant)
    );

    assign grant_idx   = r_grant_idx;
    assign grant_valid = (r_state == ARB_GRANT);

    assign w_owner_req = req[r_grant_idx];
    // The current owner never competes in its own handover; when idle grant
    // is zero so the full request vector is searched.
    assign w_cand      = req & ~grant;
    assign w_pick      = f_rr_pick(w_cand, r_last_idx);
    assign w_rearb     = (r_state == ARB_IDLE) || !w_owner_req || w_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_grant_idx <= '0;
            r_last_idx  <= arb_idx_t'(N_REQ - 1);
        end else if (w_rearb) begin
            if (w_pick.found) begin
                r_state     <= ARB_GRANT;
                r_grant_idx <= w_pick.idx;
                r_last_idx  <= w_pick.idx;
            end else begin
                r_state     <= ARB_IDLE;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int c_hold_w = $clog2(MAX_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);

    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_timeout_pulse;

    // Preempt only a still-requesting owner with a competitor waiting; a
    // voluntary release in the same cycle is an ordinary handover.
    assign w_force = (r_state == ARB_GRANT) && w_owner_req &&
                     (r_hold_cnt == c_hold_last) && (|w_cand);

    assign timeout_pulse = r_timeout_pulse;

    // The counter saturates at the threshold, so a competitor that shows
    // up after a long solo hold preempts the owner on the very next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt      <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_force;
            if (w_rearb) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != c_hold_last) begin
                r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            end
        end
    end
`else
    assign w_force       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule : rr_arbiter_4
`default_nettype wire
